dac_frame_sequencer: RTL and testbench



---
 rtl/dac_frame_sequencer.sv | 120 ++++++++++++
 tb/tb_dac_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_sequencer.sv
// Sawtooth sample generator for the four LTC2624 channels. On each sample tick it
// emits one 32-bit DAC command word per enabled channel over a valid/ready handshake.
module dac_frame_sequencer #(
  parameter int unsigned CLK_DIV      = 1000,
  parameter logic [11:0] PHASE_OFFSET = 12'h400,
  parameter logic [3:0]  DAC_CMD      = 4'h3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [3:0]  CHANNEL_EN,
  input  logic [11:0] STEP,
  output logic [31:0] FRAME,
  output logic        FRAME_VALID,
  input  logic        FRAME_READY,
  output logic        OVERRUN,
  output logic [15:0] SAMPLE_COUNT,
  output logic [2:0]  STATE
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    LOAD      = 3'd2,
    SEND      = 3'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [11:0]      acc;
  logic [3:0]       mask;
  logic [1:0]       idx;
  logic [1:0]       first_idx;
  logic [1:0]       next_idx;
  logic             next_found;
  logic [11:0]      chan_data;

  assign tick      = ENABLE && (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign STATE     = state;
  assign chan_data = acc + 12'(32'(idx) * 32'(PHASE_OFFSET));

  // Lowest enabled channel for a new burst, and next channel above idx within the latched mask
  always_comb begin
    first_idx  = 2'd0;
    next_idx   = 2'd0;
    next_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (CHANNEL_EN[i]) first_idx = 2'(i);
      if (mask[i] && (2'(i) > idx)) begin
        next_found = 1'b1;
        next_idx   = 2'(i);
      end
    end
  end

  // Sample tick divider, held at zero while disabled
  always_ff @(posedge CLOCK) begin
    if (RESET || !ENABLE || tick) tick_cnt <= '0;
    else                          tick_cnt <= tick_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= IDLE;
      FRAME        <= '0;
      FRAME_VALID  <= 1'b0;
      OVERRUN      <= 1'b0;
      SAMPLE_COUNT <= '0;
      acc          <= '0;
      mask         <= '0;
      idx          <= '0;
    end else begin
      // A tick that lands during a burst is dropped, not queued
      if (tick && (state == LOAD || state == SEND)) OVERRUN <= 1'b1;

      case (state)
        IDLE: begin
          if (ENABLE) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!ENABLE) begin
            state <= IDLE;
          end else if (tick) begin
            mask <= CHANNEL_EN;
            if (CHANNEL_EN == 4'd0) begin
              acc          <= acc + STEP;
              SAMPLE_COUNT <= SAMPLE_COUNT + 16'd1;
            end else begin
              idx   <= first_idx;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          FRAME       <= {8'h00, DAC_CMD, 2'b00, idx, chan_data, 4'h0};
          FRAME_VALID <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (FRAME_READY) begin
            FRAME_VALID <= 1'b0;
            if (next_found) begin
              idx   <= next_idx;
              state <= LOAD;
            end else begin
              acc          <= acc + STEP;
              SAMPLE_COUNT <= SAMPLE_COUNT + 16'd1;
              state        <= ENABLE ? WAIT_TICK : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed and randomized bench for dac_frame_sequencer against a queue-based
// transaction model of ticks, bursts and the sawtooth accumulator.
module tb_dac_frame_sequencer;

  localparam int unsigned CLK_DIV      = 8;
  localparam logic [11:0] PHASE_OFFSET = 12'h400;
  localparam logic [3:0]  DAC_CMD      = 4'h3;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [3:0]  CHANNEL_EN;
  logic [11:0] STEP;
  logic [31:0] FRAME;
  logic        FRAME_VALID;
  logic        FRAME_READY;
  logic        OVERRUN;
  logic [15:0] SAMPLE_COUNT;
  logic [2:0]  STATE;

  dac_frame_sequencer #(
    .CLK_DIV     (CLK_DIV),
    .PHASE_OFFSET(PHASE_OFFSET),
    .DAC_CMD     (DAC_CMD)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .ENABLE      (ENABLE),
    .CHANNEL_EN  (CHANNEL_EN),
    .STEP        (STEP),
    .FRAME       (FRAME),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .OVERRUN     (OVERRUN),
    .SAMPLE_COUNT(SAMPLE_COUNT),
    .STATE       (STATE)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: enabled-cycle tick count, sawtooth value, pending burst words
  int unsigned m_cnt;
  logic [11:0] m_acc;
  logic [15:0] m_count;
  logic        m_ovr;
  logic [31:0] m_q[$];
  int          m_due;
  int          cyc;
  int          n_valid;
  logic [31:0] got_frame[$];
  int          got_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk_frame(input int ch, input logic [11:0] acc);
    logic [11:0] d;
    d = 12'((int'(acc) + ch * int'(PHASE_OFFSET)) % 4096);
    return {8'h00, DAC_CMD, 4'(ch), d, 4'h0};
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_acc   = '0;
    m_count = '0;
    m_ovr   = 1'b0;
    m_q.delete();
    m_due   = -1;
  endtask

  task automatic clear_log();
    got_frame.delete();
    got_cyc.delete();
    n_valid = 0;
  endtask

  // One clock: check the state left by the previous edge, drive inputs, predict the next edge
  task automatic cycle(input logic en, input logic [3:0] chen, input logic [11:0] st, input logic rdy);
    logic busy, hs, tk;
    @(negedge CLOCK);
    cyc++;
    check("sample_count", 32'(SAMPLE_COUNT), 32'(m_count));
    check("overrun", 32'(OVERRUN), 32'(m_ovr));
    if (m_due == 2) check("load_bubble", 32'(FRAME_VALID), 32'd0);
    if (m_due == 1) check("valid_latency", 32'(FRAME_VALID), 32'd1);
    if (m_due > 0) m_due--;
    if (FRAME_VALID) n_valid++;

    ENABLE      = en;
    CHANNEL_EN  = chen;
    STEP        = st;
    FRAME_READY = rdy;

    busy  = (m_q.size() != 0);
    hs    = FRAME_VALID && rdy;
    tk    = en && (m_cnt == CLK_DIV - 1);
    m_cnt = en ? (tk ? 0 : m_cnt + 1) : 0;

    if (hs) begin
      got_frame.push_back(FRAME);
      got_cyc.push_back(cyc);
      check("frame_expected", 32'(m_q.size() != 0), 32'd1);
      if (m_q.size() != 0) begin
        check("frame", FRAME, m_q.pop_front());
        if (m_q.size() == 0) begin
          m_acc   = m_acc + st;
          m_count = m_count + 16'd1;
        end else begin
          m_due = 2;
        end
      end
    end
    if (tk) begin
      if (busy) begin
        m_ovr = 1'b1;
      end else if (chen == 4'd0) begin
        m_acc   = m_acc + st;
        m_count = m_count + 16'd1;
      end else begin
        for (int n = 0; n < 4; n++) if (chen[n]) m_q.push_back(mk_frame(n, m_acc));
        m_due = 2;
      end
    end
  endtask

  // Reset is applied with current inputs held, then released with the sequencer disabled
  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET       = 1'b0;
    ENABLE      = 1'b0;
    FRAME_READY = 1'b0;
    model_reset();
  endtask

  task automatic run_until_frames(input int n, input logic [3:0] chen, input logic [11:0] st, input int limit);
    for (int i = 0; i < limit && got_frame.size() < n; i++) cycle(1'b1, chen, st, 1'b1);
    check("frames_seen", 32'(got_frame.size()), 32'(n));
  endtask

  task automatic wait_valid(input logic [3:0] chen, input logic [11:0] st, input int limit);
    for (int i = 0; i < limit && !FRAME_VALID; i++) cycle(1'b1, chen, st, 1'b0);
    check("valid_seen", 32'(FRAME_VALID), 32'd1);
  endtask

  initial begin
    logic [31:0] exp1[3];
    logic [31:0] exp2[4];
    logic [31:0] exp5[3];
    logic [31:0] held;
    exp1 = '{32'h00300000, 32'h00300100, 32'h00300200};
    exp2 = '{32'h00300000, 32'h00314000, 32'h00328000, 32'h0033C000};
    exp5 = '{32'h0033C000, 32'h0033BFF0, 32'h0033BFE0};

    RESET = 1'b1; ENABLE = 1'b0; CHANNEL_EN = '0; STEP = '0; FRAME_READY = 1'b0;
    cyc = 0;
    model_reset();
    clear_log();
    do_reset();
    check("rst_frame", FRAME, 32'h0);
    check("rst_valid", 32'(FRAME_VALID), 32'd0);
    check("rst_state", 32'(STATE), 32'd0);

    // Single channel, periodic frames
    clear_log();
    run_until_frames(3, 4'b0001, 12'h010, 60);
    if (got_frame.size() >= 3) begin
      for (int i = 0; i < 3; i++) check("t1_frame", got_frame[i], exp1[i]);
      check("t1_spacing_a", 32'(got_cyc[1] - got_cyc[0]), 32'd8);
      check("t1_spacing_b", 32'(got_cyc[2] - got_cyc[1]), 32'd8);
    end
    check("t1_valid_cycles", 32'(n_valid), 32'd3);
    cycle(1'b1, 4'b0001, 12'h010, 1'b1);
    check("t1_count", 32'(SAMPLE_COUNT), 32'd3);

    // Four-channel burst with one-cycle gaps
    do_reset();
    clear_log();
    run_until_frames(4, 4'b1111, 12'h010, 60);
    if (got_frame.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t2_frame", got_frame[i], exp2[i]);
      for (int i = 1; i < 4; i++) check("t2_gap", 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
    end

    // Backpressure: word held stable for five stalled cycles
    do_reset();
    clear_log();
    wait_valid(4'b0001, 12'h010, 40);
    held = FRAME;
    for (int k = 1; k < 5; k++) begin
      cycle(1'b1, 4'b0001, 12'h010, 1'b0);
      check("t3_hold_frame", FRAME, held);
      check("t3_hold_valid", 32'(FRAME_VALID), 32'd1);
    end
    cycle(1'b1, 4'b0001, 12'h010, 1'b1);
    check("t3_accepted", 32'(got_frame.size()), 32'd1);
    if (got_frame.size() >= 1) check("t3_frame", got_frame[0], 32'h00300000);
    cycle(1'b1, 4'b0001, 12'h010, 1'b1);
    check("t3_overrun", 32'(OVERRUN), 32'd0);

    // Overrun: second tick lands during a stalled burst
    do_reset();
    clear_log();
    wait_valid(4'b0001, 12'h010, 40);
    repeat (12) cycle(1'b1, 4'b0001, 12'h010, 1'b0);
    repeat (10) cycle(1'b0, 4'b0001, 12'h010, 1'b1);
    check("t4_overrun", 32'(OVERRUN), 32'd1);
    check("t4_bursts", 32'(got_frame.size()), 32'd1);
    check("t4_count", 32'(SAMPLE_COUNT), 32'd1);

    // Reset while a word is pending clears everything, including sticky state
    clear_log();
    wait_valid(4'b0001, 12'h010, 40);
    do_reset();
    check("t6_frame", FRAME, 32'h0);
    check("t6_valid", 32'(FRAME_VALID), 32'd0);
    check("t6_state", 32'(STATE), 32'd0);
    check("t6_overrun", 32'(OVERRUN), 32'd0);
    check("t6_count", 32'(SAMPLE_COUNT), 32'd0);
    clear_log();
    run_until_frames(1, 4'b0001, 12'h010, 40);
    if (got_frame.size() >= 1) check("t6_first", got_frame[0], 32'h00300000);

    // Accumulator wrap on channel D
    do_reset();
    clear_log();
    run_until_frames(3, 4'b1000, 12'hFFF, 60);
    if (got_frame.size() >= 3)
      for (int i = 0; i < 3; i++) check("t5_frame", got_frame[i], exp5[i]);

    // Randomized traffic against the model
    do_reset();
    clear_log();
    for (int i = 0; i < 4000; i++) begin
      logic en, rdy;
      en  = ($urandom_range(0, 31) != 0);
      rdy = (i % 1000 < 700) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cycle(en, 4'($urandom_range(0, 15)), 12'($urandom), rdy);
    end
    repeat (40) cycle(1'b0, 4'($urandom_range(0, 15)), 12'($urandom), 1'b1);
    check("drain_empty", 32'(m_q.size()), 32'd0);
    check("drain_idle", 32'(STATE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
